fwd_result_pipe: RTL and testbench

FWD_RESULT_PIPE -- requirements
Module: fwd_result_pipe

---
 rtl/fwd_pipe_pkg.sv | 35 +++
 rtl/fwd_pipe_lane.sv | 79 +++++++
 rtl/fwd_result_pipe.sv | 108 ++++++++++
 tb/tb_fwd_result_pipe.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pipe_pkg.sv
// Shared constants, types and helpers for the forwarding result pipeline.
package fwd_pipe_pkg;

    localparam int DEF_LANES        = 2;
    localparam int DEF_DEPTH        = 7;
    localparam int DEF_DW           = 128;
    localparam int DEF_AW           = 7;
    localparam int DEF_NSRC         = 6;
    localparam int DEF_FLUSH_STAGES = 2;

    // Latency field width; DEPTH is capped at 15 so four bits always suffice.
    localparam int LAT_W = 4;

    typedef logic [LAT_W-1:0] lat_t;

    // Width-independent part of a stage entry. The dst and data fields depend
    // on module parameters and travel alongside this struct in the lane.
    typedef struct packed {
        logic valid;
        logic reg_wr;
        lat_t lat;
    } stage_meta_t;

    // Latency 0 behaves as 1; anything beyond the pipe depth behaves as DEPTH.
    function automatic lat_t clamp_lat(input lat_t lat, input int depth);
        if (lat == '0) begin
            return lat_t'(1);
        end
        if (int'(lat) > depth) begin
            return lat_t'(depth);
        end
        return lat;
    endfunction

endpackage

// File: rtl/fwd_pipe_lane.sv
// One issue lane: a DEPTH-stage shift register of result entries. Stage k
// of the pipe lives at array index k-1. The shift is unconditional; flush
// kills the shallow stages after the shift and blocks the stage-1 load.
module fwd_pipe_lane
    import fwd_pipe_pkg::*;
#(
    parameter int DEPTH        = DEF_DEPTH,
    parameter int DW           = DEF_DW,
    parameter int AW           = DEF_AW,
    parameter int FLUSH_STAGES = DEF_FLUSH_STAGES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   ld_valid,
    input  logic                   ld_reg_wr,
    input  logic [AW-1:0]          ld_dst,
    input  logic [LAT_W-1:0]       ld_lat,
    input  logic [DW-1:0]          ld_data,
    output logic [DEPTH-1:0]       stg_valid,
    output logic [DEPTH-1:0]       stg_reg_wr,
    output logic [DEPTH*AW-1:0]    stg_dst,
    output logic [DEPTH*LAT_W-1:0] stg_lat,
    output logic [DEPTH*DW-1:0]    stg_data
);

    stage_meta_t   meta_d [DEPTH];
    stage_meta_t   meta_q [DEPTH];
    logic [AW-1:0] dst_d  [DEPTH];
    logic [AW-1:0] dst_q  [DEPTH];
    logic [DW-1:0] data_d [DEPTH];
    logic [DW-1:0] data_q [DEPTH];

    // Next-state: load stage 1, shift the rest down, kill shallow stages on flush.
    always_comb begin
        meta_d[0].valid  = ld_valid & ~flush;
        meta_d[0].reg_wr = ld_reg_wr;
        meta_d[0].lat    = clamp_lat(ld_lat, DEPTH);
        dst_d[0]         = ld_dst;
        data_d[0]        = ld_data;
        for (int k = 1; k < DEPTH; k++) begin
            meta_d[k] = meta_q[k-1];
            dst_d[k]  = dst_q[k-1];
            data_d[k] = data_q[k-1];
            if (flush && (k < FLUSH_STAGES)) begin
                meta_d[k].valid = 1'b0;
            end
        end
    end

    // Stage registers; reset empties the lane immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                meta_q[k] <= '0;
                dst_q[k]  <= '0;
                data_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                meta_q[k] <= meta_d[k];
                dst_q[k]  <= dst_d[k];
                data_q[k] <= data_d[k];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_flat
            assign stg_valid[gi]                   = meta_q[gi].valid;
            assign stg_reg_wr[gi]                  = meta_q[gi].reg_wr;
            assign stg_lat[gi*LAT_W +: LAT_W]      = meta_q[gi].lat;
            assign stg_dst[gi*AW +: AW]            = dst_q[gi];
            assign stg_data[gi*DW +: DW]           = data_q[gi];
        end
    endgenerate

endmodule

// File: rtl/fwd_result_pipe.sv
// Multi-lane result pipeline with operand forwarding. Each lane carries
// in-flight results toward writeback; source lookups pick the youngest
// matching entry and stall issue when that entry has not produced its value.
module fwd_result_pipe
    import fwd_pipe_pkg::*;
#(
    parameter int LANES        = DEF_LANES,
    parameter int DEPTH        = DEF_DEPTH,
    parameter int DW           = DEF_DW,
    parameter int AW           = DEF_AW,
    parameter int NSRC         = DEF_NSRC,
    parameter int FLUSH_STAGES = DEF_FLUSH_STAGES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LANES-1:0]      in_valid,
    input  logic [LANES-1:0]      in_reg_wr,
    input  logic [LANES*AW-1:0]   in_dst,
    input  logic [LANES*4-1:0]    in_latency,
    input  logic [LANES*DW-1:0]   in_data,
    input  logic                  flush,
    input  logic [NSRC*AW-1:0]    src_addr,
    output logic [NSRC-1:0]       fwd_hit,
    output logic [NSRC*DW-1:0]    fwd_data,
    output logic                  stall,
    output logic [LANES-1:0]      wb_en,
    output logic [LANES*AW-1:0]   wb_addr,
    output logic [LANES*DW-1:0]   wb_data
);

    logic [LANES-1:0]       ld_valid;
    logic [DEPTH-1:0]       lane_valid  [LANES];
    logic [DEPTH-1:0]       lane_reg_wr [LANES];
    logic [DEPTH*AW-1:0]    lane_dst    [LANES];
    logic [DEPTH*LAT_W-1:0] lane_lat    [LANES];
    logic [DEPTH*DW-1:0]    lane_data   [LANES];

    // Stall holds every lane back together so issue order is preserved.
    assign ld_valid = in_valid & {LANES{~stall}};

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            fwd_pipe_lane #(
                .DEPTH        (DEPTH),
                .DW           (DW),
                .AW           (AW),
                .FLUSH_STAGES (FLUSH_STAGES)
            ) u_lane (
                .clk        (clk),
                .rst        (rst),
                .flush      (flush),
                .ld_valid   (ld_valid[gi]),
                .ld_reg_wr  (in_reg_wr[gi]),
                .ld_dst     (in_dst[gi*AW +: AW]),
                .ld_lat     (in_latency[gi*4 +: LAT_W]),
                .ld_data    (in_data[gi*DW +: DW]),
                .stg_valid  (lane_valid[gi]),
                .stg_reg_wr (lane_reg_wr[gi]),
                .stg_dst    (lane_dst[gi]),
                .stg_lat    (lane_lat[gi]),
                .stg_data   (lane_data[gi])
            );

            // The deepest stage drives writeback; fields are zeroed when idle.
            assign wb_en[gi]              = lane_valid[gi][DEPTH-1] & lane_reg_wr[gi][DEPTH-1];
            assign wb_addr[gi*AW +: AW]   = wb_en[gi] ? lane_dst[gi][(DEPTH-1)*AW +: AW] : '0;
            assign wb_data[gi*DW +: DW]   = wb_en[gi] ? lane_data[gi][(DEPTH-1)*DW +: DW] : '0;
        end
    endgenerate

    logic          sel_found;
    logic          sel_ready;
    logic [DW-1:0] sel_data;

    // Per port: scan oldest to youngest so the last match is the youngest one.
    always_comb begin
        stall     = 1'b0;
        fwd_hit   = '0;
        fwd_data  = '0;
        sel_found = 1'b0;
        sel_ready = 1'b0;
        sel_data  = '0;
        for (int p = 0; p < NSRC; p++) begin
            sel_found = 1'b0;
            sel_ready = 1'b0;
            sel_data  = '0;
            for (int s = DEPTH - 1; s >= 0; s--) begin
                for (int l = 0; l < LANES; l++) begin
                    if (lane_valid[l][s] && lane_reg_wr[l][s] &&
                        (lane_dst[l][s*AW +: AW] == src_addr[p*AW +: AW])) begin
                        sel_found = 1'b1;
                        sel_ready = (lane_lat[l][s*LAT_W +: LAT_W] <= LAT_W'(s + 1));
                        sel_data  = lane_data[l][s*DW +: DW];
                    end
                end
            end
            if (sel_found && !sel_ready) begin
                stall = 1'b1;
            end
            if (sel_found && sel_ready) begin
                fwd_hit[p]             = 1'b1;
                fwd_data[p*DW +: DW]   = sel_data;
            end
        end
    end

endmodule

// File: tb/tb_fwd_result_pipe.sv
// Bench for fwd_result_pipe: directed scenarios plus a randomized run checked
// against a list-of-instructions model of the forwarding rules.
`timescale 1ns/1ps
module tb_fwd_result_pipe;

    localparam int LANES = 2;
    localparam int DEPTH = 7;
    localparam int DW    = 128;
    localparam int AW    = 7;
    localparam int NSRC  = 6;
    localparam int FS    = 2;
    localparam int IDLE_ADDR = 127;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [LANES-1:0]      in_valid;
    logic [LANES-1:0]      in_reg_wr;
    logic [LANES*AW-1:0]   in_dst;
    logic [LANES*4-1:0]    in_latency;
    logic [LANES*DW-1:0]   in_data;
    logic                  flush;
    logic [NSRC*AW-1:0]    src_addr;
    logic [NSRC-1:0]       fwd_hit;
    logic [NSRC*DW-1:0]    fwd_data;
    logic                  stall;
    logic [LANES-1:0]      wb_en;
    logic [LANES*AW-1:0]   wb_addr;
    logic [LANES*DW-1:0]   wb_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fwd_result_pipe #(
        .LANES(LANES), .DEPTH(DEPTH), .DW(DW), .AW(AW), .NSRC(NSRC), .FLUSH_STAGES(FS)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_reg_wr(in_reg_wr), .in_dst(in_dst),
        .in_latency(in_latency), .in_data(in_data), .flush(flush), .src_addr(src_addr),
        .fwd_hit(fwd_hit), .fwd_data(fwd_data), .stall(stall),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
    );

    // ---------------- reference model: list of in-flight instructions -------
    typedef struct {
        int            lane;
        int            stage;   // edges since issue, plus one
        bit            wr;
        int            dst;
        int            lat;     // raw requested latency
        logic [DW-1:0] data;
    } ent_t;

    ent_t q[$];

    function automatic int eff_lat(input int l);
        if (l == 0) return 1;
        if (l > DEPTH) return DEPTH;
        return l;
    endfunction

    function automatic void model_lookup(input int addr, output bit found, output bit ready,
                                         output logic [DW-1:0] d);
        int bs = DEPTH + 1;
        int bl = -1;
        found = 0; ready = 0; d = '0;
        foreach (q[i]) begin
            if (q[i].wr && q[i].dst == addr &&
                (q[i].stage < bs || (q[i].stage == bs && q[i].lane > bl))) begin
                bs = q[i].stage; bl = q[i].lane;
                found = 1; ready = (q[i].stage >= eff_lat(q[i].lat)); d = q[i].data;
            end
        end
    endfunction

    function automatic bit model_stall();
        bit f, r;
        logic [DW-1:0] d;
        bit st = 0;
        for (int p = 0; p < NSRC; p++) begin
            model_lookup(int'(src_addr[p*AW +: AW]), f, r, d);
            if (f && !r) st = 1;
        end
        return st;
    endfunction

    function automatic void model_wb(input int l, output bit en, output int addr,
                                     output logic [DW-1:0] d);
        en = 0; addr = 0; d = '0;
        foreach (q[i]) begin
            if (q[i].lane == l && q[i].stage == DEPTH && q[i].wr) begin
                en = 1; addr = q[i].dst; d = q[i].data;
            end
        end
    endfunction

    // Advance the model across one edge using the inputs currently applied.
    function automatic void model_advance(input bit st);
        ent_t nq[$];
        foreach (q[i]) begin
            ent_t e;
            e = q[i];
            e.stage++;
            if (e.stage > DEPTH) continue;
            if (flush && e.stage <= FS) continue;
            nq.push_back(e);
        end
        for (int l = 0; l < LANES; l++) begin
            if (in_valid[l] && !st && !flush) begin
                ent_t n;
                n.lane = l; n.stage = 1; n.wr = in_reg_wr[l];
                n.dst = int'(in_dst[l*AW +: AW]); n.lat = int'(in_latency[l*4 +: 4]);
                n.data = in_data[l*DW +: DW];
                nq.push_back(n);
                $display("issue lane=%0d dst=%0d lat=%0d wr=%0b t=%0t", l, n.dst, n.lat, n.wr, $time);
            end
        end
        q = nq;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        bit st;
        st = model_stall();
        @(posedge clk);
        model_advance(st);
        @(negedge clk);
    endtask

    task automatic set_lane(input int l, input bit v, input bit wr, input int dst,
                            input int lat, input logic [DW-1:0] d);
        in_valid[l]              = v;
        in_reg_wr[l]             = wr;
        in_dst[l*AW +: AW]       = AW'(dst);
        in_latency[l*4 +: 4]     = 4'(lat);
        in_data[l*DW +: DW]      = d;
    endtask

    task automatic set_src(input int p, input int a);
        src_addr[p*AW +: AW] = AW'(a);
    endtask

    task automatic clear_inputs();
        in_valid = '0; in_reg_wr = '0; in_dst = '0; in_latency = '0; in_data = '0;
        flush = 1'b0;
        for (int p = 0; p < NSRC; p++) set_src(p, IDLE_ADDR);
    endtask

    task automatic idle(input int n);
        in_valid = '0; flush = 1'b0;
        repeat (n) tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        set_lane(0, 1, 1, 5, 1, 128'h1);
        set_src(0, 5);
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        checks++; if (wb_en !== '0)    begin errors++; $display("FAIL reset_wb_en got=%0h exp=0", wb_en); end
        checks++; if (wb_addr !== '0)  begin errors++; $display("FAIL reset_wb_addr got=%0h exp=0", wb_addr); end
        checks++; if (wb_data !== '0)  begin errors++; $display("FAIL reset_wb_data got=%0h exp=0", wb_data); end
        checks++; if (fwd_hit !== '0)  begin errors++; $display("FAIL reset_fwd_hit got=%0h exp=0", fwd_hit); end
        checks++; if (fwd_data !== '0) begin errors++; $display("FAIL reset_fwd_data got=%0h exp=0", fwd_data); end
        checks++; if (stall !== 1'b0)  begin errors++; $display("FAIL reset_stall got=%0b exp=0", stall); end
        clear_inputs();
        rst = 1'b0;
        q.delete();
        #1;
        checks++; if (stall !== 1'b0)  begin errors++; $display("FAIL post_reset_stall got=%0b exp=0", stall); end
        checks++; if (wb_en !== '0)    begin errors++; $display("FAIL post_reset_wb_en got=%0h exp=0", wb_en); end
    endtask

    task automatic test_basic();
        clear_inputs();
        set_src(0, 5);
        set_lane(0, 1, 1, 5, 2, 128'hAA);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL basic_pre_stall got=%0b exp=0", stall); end
        tick();
        set_lane(0, 0, 0, 0, 0, '0); #1;
        checks++; if (stall !== 1'b1)   begin errors++; $display("FAIL basic_stall got=%0b exp=1", stall); end
        checks++; if (fwd_hit[0] !== 0) begin errors++; $display("FAIL basic_early_hit got=%0b exp=0", fwd_hit[0]); end
        tick(); #1;
        checks++; if (fwd_hit[0] !== 1'b1) begin errors++; $display("FAIL basic_hit got=%0b exp=1", fwd_hit[0]); end
        checks++; if (fwd_data[DW-1:0] !== 128'hAA) begin errors++; $display("FAIL basic_data got=%0h exp=aa", fwd_data[DW-1:0]); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL basic_stall_clear got=%0b exp=0", stall); end
        repeat (4) tick(); #1;
        checks++; if (wb_en !== 2'b00) begin errors++; $display("FAIL basic_wb_early got=%0b exp=00", wb_en); end
        tick(); #1;
        checks++; if (wb_en !== 2'b01) begin errors++; $display("FAIL basic_wb_en got=%0b exp=01", wb_en); end
        checks++; if (wb_addr[AW-1:0] !== 7'd5) begin errors++; $display("FAIL basic_wb_addr got=%0d exp=5", wb_addr[AW-1:0]); end
        checks++; if (wb_data[DW-1:0] !== 128'hAA) begin errors++; $display("FAIL basic_wb_data got=%0h exp=aa", wb_data[DW-1:0]); end
        tick(); #1;
        checks++; if (wb_en !== 2'b00) begin errors++; $display("FAIL basic_wb_late got=%0b exp=00", wb_en); end
        clear_inputs();
    endtask

    task automatic test_same_cycle();
        clear_inputs();
        set_src(0, 9);
        set_lane(0, 1, 1, 9, 1, 128'h1);
        set_lane(1, 1, 1, 9, 1, 128'h2);
        tick();
        in_valid = '0; #1;
        checks++; if (fwd_hit[0] !== 1'b1) begin errors++; $display("FAIL same_hit got=%0b exp=1", fwd_hit[0]); end
        checks++; if (fwd_data[DW-1:0] !== 128'h2) begin errors++; $display("FAIL same_youngest got=%0h exp=2", fwd_data[DW-1:0]); end
        repeat (6) tick(); #1;
        checks++; if (wb_en !== 2'b11) begin errors++; $display("FAIL same_wb_both got=%0b exp=11", wb_en); end
        checks++; if (wb_addr !== {7'd9, 7'd9}) begin errors++; $display("FAIL same_wb_addr got=%0h exp=489", wb_addr); end
        checks++; if (wb_data !== {128'h2, 128'h1}) begin errors++; $display("FAIL same_wb_data got=%0h exp=2/1", wb_data); end
        idle(2);
        clear_inputs();
    endtask

    task automatic test_older_ready();
        clear_inputs();
        set_src(0, 3);
        set_lane(0, 1, 1, 3, 1, 128'h0A);
        tick();
        set_lane(0, 0, 0, 0, 0, '0);
        set_lane(1, 1, 1, 3, 6, 128'h0B);
        tick();
        set_lane(1, 0, 0, 0, 0, '0);
        for (int s = 1; s <= 6; s++) begin
            #1;
            checks++; if (stall !== (s < 6)) begin errors++; $display("FAIL older_stall s=%0d got=%0b exp=%0b", s, stall, (s < 6)); end
            checks++; if (fwd_hit[0] !== (s >= 6)) begin errors++; $display("FAIL older_hit s=%0d got=%0b exp=%0b", s, fwd_hit[0], (s >= 6)); end
            checks++; if (fwd_data[DW-1:0] !== ((s >= 6) ? 128'h0B : 128'h0)) begin errors++; $display("FAIL older_data s=%0d got=%0h", s, fwd_data[DW-1:0]); end
            tick();
        end
        idle(DEPTH);
        clear_inputs();
    endtask

    task automatic test_flush();
        clear_inputs();
        set_src(0, 4); set_src(1, 6); set_src(2, 8);
        set_lane(1, 1, 1, 6, 1, 128'h66);
        tick();
        set_lane(1, 0, 0, 0, 0, '0);
        set_lane(0, 1, 1, 4, 1, 128'h44);
        tick(); #1;
        checks++; if (fwd_hit[0] !== 1'b1) begin errors++; $display("FAIL flush_pre_hit got=%0b exp=1", fwd_hit[0]); end
        flush = 1'b1;
        set_lane(0, 1, 1, 8, 1, 128'h88);
        tick();
        flush = 1'b0;
        set_lane(0, 0, 0, 0, 0, '0); #1;
        checks++; if (fwd_hit[0] !== 1'b0) begin errors++; $display("FAIL flush_killed got=%0b exp=0", fwd_hit[0]); end
        checks++; if (fwd_hit[2] !== 1'b0) begin errors++; $display("FAIL flush_blocked got=%0b exp=0", fwd_hit[2]); end
        checks++; if (fwd_hit[1] !== 1'b1) begin errors++; $display("FAIL flush_deep_hit got=%0b exp=1", fwd_hit[1]); end
        checks++; if (fwd_data[DW +: DW] !== 128'h66) begin errors++; $display("FAIL flush_deep_data got=%0h exp=66", fwd_data[DW +: DW]); end
        for (int i = 1; i <= 7; i++) begin
            tick(); #1;
            checks++; if (wb_en !== ((i == 4) ? 2'b10 : 2'b00)) begin errors++; $display("FAIL flush_wb i=%0d got=%0b", i, wb_en); end
            checks++; if ((fwd_hit[0] | fwd_hit[2]) !== 1'b0) begin errors++; $display("FAIL flush_ghost i=%0d got=%0b exp=0", i, fwd_hit); end
        end
        clear_inputs();
    endtask

    task automatic test_stall_reissue();
        clear_inputs();
        set_src(0, 5); set_src(1, 10);
        set_lane(0, 1, 1, 5, 3, 128'h55);
        tick();
        set_lane(0, 0, 0, 0, 0, '0);
        set_lane(1, 1, 1, 10, 1, 128'h1010); #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL reissue_stall1 got=%0b exp=1", stall); end
        tick(); #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL reissue_stall2 got=%0b exp=1", stall); end
        checks++; if (fwd_hit[1] !== 1'b0) begin errors++; $display("FAIL reissue_bubble1 got=%0b exp=0", fwd_hit[1]); end
        tick(); #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reissue_release got=%0b exp=0", stall); end
        checks++; if (fwd_hit[1] !== 1'b0) begin errors++; $display("FAIL reissue_bubble2 got=%0b exp=0", fwd_hit[1]); end
        checks++; if (fwd_data[DW-1:0] !== 128'h55) begin errors++; $display("FAIL reissue_old_data got=%0h exp=55", fwd_data[DW-1:0]); end
        tick();
        set_lane(1, 0, 0, 0, 0, '0); #1;
        checks++; if (fwd_hit[1] !== 1'b1) begin errors++; $display("FAIL reissue_hit got=%0b exp=1", fwd_hit[1]); end
        checks++; if (fwd_data[DW +: DW] !== 128'h1010) begin errors++; $display("FAIL reissue_data got=%0h exp=1010", fwd_data[DW +: DW]); end
        repeat (5) tick(); #1;
        checks++; if (wb_en[1] !== 1'b0) begin errors++; $display("FAIL reissue_wb_early got=%0b exp=0", wb_en[1]); end
        tick(); #1;
        checks++; if (wb_en[1] !== 1'b1) begin errors++; $display("FAIL reissue_wb got=%0b exp=1", wb_en[1]); end
        checks++; if (wb_addr[AW +: AW] !== 7'd10) begin errors++; $display("FAIL reissue_wb_addr got=%0d exp=10", wb_addr[AW +: AW]); end
        idle(2);
        clear_inputs();
    endtask

    task automatic test_random();
        bit f, r, exp_st, exp_en;
        int exp_addr;
        logic [DW-1:0] d, exp_d;
        clear_inputs();
        for (int cyc = 0; cyc < 300; cyc++) begin
            for (int l = 0; l < LANES; l++) begin
                set_lane(l, ($urandom_range(0, 1) == 1), ($urandom_range(0, 7) != 0),
                         int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                         {$urandom, $urandom, $urandom, $urandom});
            end
            for (int p = 0; p < NSRC; p++) set_src(p, int'($urandom_range(0, 7)));
            flush = ($urandom_range(0, 9) == 0);
            #1;
            exp_st = model_stall();
            checks++; if (stall !== exp_st) begin errors++; $display("FAIL rand_stall cyc=%0d got=%0b exp=%0b", cyc, stall, exp_st); end
            for (int p = 0; p < NSRC; p++) begin
                model_lookup(int'(src_addr[p*AW +: AW]), f, r, d);
                exp_d = (f && r) ? d : '0;
                checks++; if (fwd_hit[p] !== (f && r)) begin errors++; $display("FAIL rand_hit cyc=%0d p=%0d got=%0b exp=%0b", cyc, p, fwd_hit[p], (f && r)); end
                checks++; if (fwd_data[p*DW +: DW] !== exp_d) begin errors++; $display("FAIL rand_data cyc=%0d p=%0d got=%0h exp=%0h", cyc, p, fwd_data[p*DW +: DW], exp_d); end
            end
            for (int l = 0; l < LANES; l++) begin
                model_wb(l, exp_en, exp_addr, d);
                checks++; if (wb_en[l] !== exp_en) begin errors++; $display("FAIL rand_wb_en cyc=%0d l=%0d got=%0b exp=%0b", cyc, l, wb_en[l], exp_en); end
                checks++; if (wb_addr[l*AW +: AW] !== AW'(exp_addr)) begin errors++; $display("FAIL rand_wb_addr cyc=%0d l=%0d got=%0d exp=%0d", cyc, l, wb_addr[l*AW +: AW], exp_addr); end
                checks++; if (wb_data[l*DW +: DW] !== d) begin errors++; $display("FAIL rand_wb_data cyc=%0d l=%0d got=%0h exp=%0h", cyc, l, wb_data[l*DW +: DW], d); end
            end
            tick();
        end
        clear_inputs();
        idle(DEPTH);
    endtask

    task automatic test_reset_mid();
        clear_inputs();
        set_src(0, 20);
        set_lane(0, 1, 1, 20, 1, 128'hA0);
        set_lane(1, 1, 1, 21, 1, 128'hA1);
        tick();
        set_lane(0, 1, 1, 20, 1, 128'hB0);
        set_lane(1, 1, 1, 22, 1, 128'hB1);
        tick();
        set_lane(0, 1, 1, 23, 1, 128'hC0);
        set_lane(1, 0, 0, 0, 0, '0);
        tick();
        in_valid = '0;
        repeat (4) tick(); #1;
        checks++; if (wb_en !== 2'b11) begin errors++; $display("FAIL rstmid_setup_wb got=%0b exp=11", wb_en); end
        checks++; if (fwd_hit[0] !== 1'b1) begin errors++; $display("FAIL rstmid_setup_hit got=%0b exp=1", fwd_hit[0]); end
        #2 rst = 1'b1;
        #1;
        checks++; if (wb_en !== '0)    begin errors++; $display("FAIL rstmid_wb_en got=%0b exp=0", wb_en); end
        checks++; if (wb_addr !== '0)  begin errors++; $display("FAIL rstmid_wb_addr got=%0h exp=0", wb_addr); end
        checks++; if (wb_data !== '0)  begin errors++; $display("FAIL rstmid_wb_data got=%0h exp=0", wb_data); end
        checks++; if (fwd_hit !== '0)  begin errors++; $display("FAIL rstmid_fwd_hit got=%0h exp=0", fwd_hit); end
        checks++; if (fwd_data !== '0) begin errors++; $display("FAIL rstmid_fwd_data got=%0h exp=0", fwd_data); end
        checks++; if (stall !== 1'b0)  begin errors++; $display("FAIL rstmid_stall got=%0b exp=0", stall); end
        q.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++; if (wb_en !== '0)   begin errors++; $display("FAIL rstmid_after_wb i=%0d got=%0b exp=0", i, wb_en); end
            checks++; if (fwd_hit !== '0) begin errors++; $display("FAIL rstmid_after_hit i=%0d got=%0h exp=0", i, fwd_hit); end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before the bench completed");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_same_cycle();
        test_older_ready();
        test_flush();
        test_stall_reissue();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
